fetch_unit: RTL and testbench

Instruction-fetch stage that consumes the decode stage's jump decision (`pc_src`, `jump_address`) and produces the IF/ID pipeline register (`if_id_instruction`, `if_id_pc_plus_four`) that feeds decode. It owns the program counter, drives a variable-latency instruction-memory request/ready handshake, and holds fetched instructions across hazard stalls. MIPS single-delay-slot semantics are enforced: a redirect takes effect after the instruction already being fetched, which is the delay slot.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and instruction memory.
// Latency: none; this bundle is wires only.
// Backpressure: memory holds imem_ready low to stretch a request; the requester keeps imem_addr stable meanwhile.
//
// Ports (master = fetch stage, slave = instruction memory):
//   imem_req    fetch request active
//   imem_addr   word address being fetched
//   imem_ready  imem_rdata is valid for imem_addr this cycle
//   imem_rdata  fetched instruction word
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over imem, fills the IF/ID register.
// Latency: zero-wait memory gives one instruction per cycle, written to IF/ID at the edge imem_ready is sampled.
// Backpressure: stall freezes IF/ID; a word arriving under stall is parked in hold_buf and the request is dropped.
//
// Ports:
//   clock, reset_n      sole clock; synchronous active-low reset
//   stall               hazard unit asks decode to keep its current IF/ID contents
//   pc_src/jump_address one-cycle redirect from decode; honoured after the delay slot
//   imem (master)       request/ready instruction-memory bus, imem_addr is the PC
//   if_id_*             IF/ID pipeline register (instruction, its PC+4, valid)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         stall,
  input  logic         pc_src,
  input  logic [31:0]  jump_address,
  fetch_unit_if.master imem,
  output logic [31:0]  if_id_instruction,
  output logic [31:0]  if_id_pc_plus_four,
  output logic         if_id_valid
);

  // FETCH: request outstanding at pc_q.
  // HOLD:  word for pc_q already captured in hold_buf_q, waiting for stall to drop.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] pc_q;
  logic [31:0] hold_buf_q;
  logic        redirect_pending_q;
  logic [31:0] redirect_target_q;

  logic [31:0] pc_plus_four;
  logic [31:0] next_pc;
  logic [31:0] complete_word;
  logic        complete;       // an instruction moves into IF/ID at this edge
  logic        capture_hold;   // memory answered while decode is stalled
  logic        bubble;         // memory still busy and decode wants something

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign pc_plus_four = pc_q + 32'd4;

  // A redirect arriving in the same cycle as a completion wins over an older
  // pending one; either way the instruction completing now is the delay slot.
  always_comb begin
    next_pc = pc_plus_four;
    if (pc_src) begin
      next_pc = jump_address;
    end else if (redirect_pending_q) begin
      next_pc = redirect_target_q;
    end
    next_pc[1:0] = 2'b00;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d        = state_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    complete       = 1'b0;
    capture_hold   = 1'b0;
    bubble         = 1'b0;
    complete_word  = imem.imem_rdata;

    // While in reset the request is dropped outright; memory tolerates this.
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          imem.imem_req = 1'b1;
          if (imem.imem_ready && !stall) begin
            complete = 1'b1;
          end else if (imem.imem_ready) begin
            capture_hold = 1'b1;
            state_d      = HOLD;
          end else if (!stall) begin
            bubble = 1'b1;
          end
        end
        HOLD: begin
          // imem_ready is ignored here: no request is outstanding.
          complete_word = hold_buf_q;
          if (!stall) begin
            complete = 1'b1;
            state_d  = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, parked word and redirect bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q               <= RESET_PC;
      hold_buf_q         <= 32'd0;
      redirect_pending_q <= 1'b0;
      redirect_target_q  <= 32'd0;
    end else begin
      if (complete) begin
        // pc_src (if any) is folded into next_pc, so nothing stays pending.
        pc_q               <= next_pc;
        redirect_pending_q <= 1'b0;
      end else if (pc_src) begin
        // Remember the target until the delay slot completes; a later
        // pc_src before that simply replaces it.
        redirect_pending_q <= 1'b1;
        redirect_target_q  <= jump_address;
      end
      if (capture_hold) begin
        hold_buf_q <= imem.imem_rdata;
      end
    end
  end

  // IF/ID register. A bubble only clears valid; the data fields keep their
  // last value so decode sees no spurious toggling.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      if_id_instruction  <= 32'd0;
      if_id_pc_plus_four <= 32'd0;
      if_id_valid        <= 1'b0;
    end else if (complete) begin
      if_id_instruction  <= complete_word;
      if_id_pc_plus_four <= pc_plus_four;
      if_id_valid        <= 1'b1;
    end else if (bubble) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        pc_src;
  logic [31:0] jump_address;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus_four;
  logic        if_id_valid;

  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;

  fetch_unit_if imem ();
  fetch_unit_if imem_w ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .stall              (stall),
    .pc_src             (pc_src),
    .jump_address       (jump_address),
    .imem               (imem),
    .if_id_instruction  (if_id_instruction),
    .if_id_pc_plus_four (if_id_pc_plus_four),
    .if_id_valid        (if_id_valid)
  );

  // Second instance for the address-wrap case: zero-wait memory returning addr.
  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clock              (clock),
    .reset_n            (reset_n),
    .stall              (1'b0),
    .pc_src             (1'b0),
    .jump_address       (32'd0),
    .imem               (imem_w),
    .if_id_instruction  (w_instr),
    .if_id_pc_plus_four (w_pc4),
    .if_id_valid        (w_valid)
  );

  assign imem_w.imem_ready = imem_w.imem_req;
  assign imem_w.imem_rdata = imem_w.imem_addr;

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Memory behaviour knobs.
  int          mem_wait;
  int          mem_cnt;
  logic [31:0] mem_xor;
  bit          rand_wait;
  bit          noise;

  // Reference model: address the stage should be fetching, whether a word is
  // parked waiting for decode, the redirect still owed, and the IF/ID contents.
  logic [31:0] m_pc;
  bit          m_hold;
  logic [31:0] m_buf;
  bit          m_redir;
  logic [31:0] m_tgt;
  logic [31:0] e_instr;
  logic [31:0] e_pc4;
  bit          e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, act as memory, predict, check after the edge.
  task automatic cycle(input bit rst_n, input bit st, input bit ps, input logic [31:0] ja);
    bit          req_now;
    bit          rdy;
    bit          done;
    logic [31:0] word;
    @(negedge clock);
    reset_n      = rst_n;
    stall        = st;
    pc_src       = ps;
    jump_address = ja;
    #1;
    req_now = rst_n && !m_hold;
    chk("imem_req", {31'd0, imem.imem_req}, {31'd0, req_now});
    if (req_now) chk("imem_addr", imem.imem_addr, m_pc);
    rdy = 1'b0;
    if (req_now) begin
      if (mem_cnt == 0) rdy = 1'b1;
      else mem_cnt--;
    end else if (noise) begin
      rdy = ($urandom_range(0, 1) != 0);
    end
    word = (rdy && req_now) ? (m_pc ^ mem_xor) : $urandom;
    imem.imem_ready = rdy;
    imem.imem_rdata = word;
    @(posedge clock);
    if (!rst_n) begin
      m_pc    = RESET_PC;
      m_hold  = 1'b0;
      m_redir = 1'b0;
      e_instr = 32'd0;
      e_pc4   = 32'd0;
      e_valid = 1'b0;
      mem_cnt = mem_wait;
    end else begin
      done = m_hold ? !st : (rdy && !st);
      if (done) begin
        e_instr = m_hold ? m_buf : word;
        e_pc4   = m_pc + 32'd4;
        e_valid = 1'b1;
        if (ps)           m_pc = {ja[31:2], 2'b00};
        else if (m_redir) m_pc = m_tgt;
        else              m_pc = m_pc + 32'd4;
        m_redir = 1'b0;
        m_hold  = 1'b0;
      end else begin
        if (!m_hold && !rdy && !st) e_valid = 1'b0;
        if (!m_hold && rdy && st) begin
          m_hold = 1'b1;
          m_buf  = word;
        end
        if (ps) begin
          m_redir = 1'b1;
          m_tgt   = {ja[31:2], 2'b00};
        end
      end
      if (req_now && rdy) mem_cnt = rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
    end
    #1;
    chk("if_id_instruction", if_id_instruction, e_instr);
    chk("if_id_pc_plus_four", if_id_pc_plus_four, e_pc4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; pc_src = 1'b0; jump_address = 32'd0;
    imem.imem_ready = 1'b0; imem.imem_rdata = 32'd0;
    mem_wait = 0; mem_cnt = 0; mem_xor = 32'd0; rand_wait = 1'b0; noise = 1'b0;
    m_pc = RESET_PC; m_hold = 1'b0; m_buf = 32'd0; m_redir = 1'b0; m_tgt = 32'd0;
    e_instr = 32'd0; e_pc4 = 32'd0; e_valid = 1'b0;

    // Reset state.
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("reset_pc", imem.imem_addr, RESET_PC);

    // Zero-wait memory returning addr: first instruction at the first edge after reset.
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("first_instr", if_id_instruction, 32'h0040_0000);
    chk("first_pc4", if_id_pc_plus_four, 32'h0040_0004);
    chk("wrap_first_instr", w_instr, 32'hFFFF_FFFC);
    chk("wrap_first_pc4", w_pc4, 32'h0000_0000);
    chk("wrap_second_addr", imem_w.imem_addr, 32'h0000_0000);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("stream_instr", if_id_instruction, 32'h0040_000C);

    // Two wait states: two bubbles before each instruction.
    mem_wait = 2; mem_cnt = 2;
    repeat (9) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wait_instr", if_id_instruction, 32'h0040_0018);
    chk("wait_valid", {31'd0, if_id_valid}, 32'd1);

    // Stall while memory answers: park the word, drop the request, freeze IF/ID.
    mem_wait = 0; mem_cnt = 0;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("hold_req", {31'd0, imem.imem_req}, 32'd0);
    chk("hold_frozen", if_id_instruction, 32'h0040_0018);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("hold_release_instr", if_id_instruction, 32'h0040_001C);
    chk("hold_resume_addr", imem.imem_addr, 32'h0040_0020);

    // Redirect while the delay slot is still waiting on memory.
    mem_wait = 2; mem_cnt = 2;
    cycle(1'b1, 1'b0, 1'b1, 32'h0040_0100);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("slot_instr", if_id_instruction, 32'h0040_0020);
    chk("jump_addr", imem.imem_addr, 32'h0040_0100);

    // Redirect during HOLD with an unaligned target.
    mem_wait = 0; mem_cnt = 0;
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0040_0203);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("hold_jump_instr", if_id_instruction, 32'h0040_0100);
    chk("hold_jump_addr", imem.imem_addr, 32'h0040_0200);

    // Reset in the middle of a wait state.
    mem_wait = 3; mem_cnt = 3;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("midreset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("midreset_req", {31'd0, imem.imem_req}, 32'd0);
    chk("midreset_pc", imem.imem_addr, RESET_PC);
    mem_wait = 0;
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'd0);

    // Randomised traffic: variable latency, stalls, redirects, stray ready in HOLD.
    rand_wait = 1'b1; noise = 1'b1;
    for (int i = 0; i < 600; i++) begin
      mem_xor = $urandom;
      cycle(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0),
            $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
